// File: rtl/fc_score_packer_pkg.sv
// ============================================================================
// Module      : fc_score_packer_pkg
// Description : Shared classifier types and score-format constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_score_packer_pkg;

  localparam int              SCORE_W       = 16;
  localparam logic signed [15:0] SCORE_MAX  = 16'sh7FFF;
  localparam logic signed [15:0] SCORE_MIN  = 16'sh8000;
  localparam int              NUM_CLASS_DEF = 10;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/score_round_sat.sv
// ============================================================================
// Module      : score_round_sat
// Description : Round-half-up, arithmetic shift and saturate ACC_W -> 16 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_round_sat
  import fc_score_packer_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 8
) (
  input  logic [ACC_W-1:0]   acc,
  output logic [SCORE_W-1:0] score
);

  localparam logic signed [ACC_W:0] c_max = {{(ACC_W+1-SCORE_W){1'b0}}, SCORE_MAX};
  localparam logic signed [ACC_W:0] c_min = {{(ACC_W+1-SCORE_W){1'b1}}, SCORE_MIN};

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shifted;

  // One guard bit keeps the rounding add from overflowing at the positive limit.
  assign w_ext = {acc[ACC_W-1], acc};

  generate
    if (FRAC_SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] c_half = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
      assign w_sum = w_ext + c_half;
    end else begin : g_pass
      assign w_sum = w_ext;
    end
  endgenerate

  assign w_shifted = w_sum >>> FRAC_SHIFT;

  always_comb begin
    if (w_shifted > c_max) begin
      score = SCORE_MAX;
    end else if (w_shifted < c_min) begin
      score = SCORE_MIN;
    end else begin
      score = w_shifted[SCORE_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fc_score_packer.sv
// ============================================================================
// Module      : fc_score_packer
// Description : Packs NUM_CLASS rescaled scores into one vector for argmax.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_score_packer
  import fc_score_packer_pkg::*;
#(
  parameter int NUM_CLASS  = NUM_CLASS_DEF,
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ACC_W-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CLASS*SCORE_W-1:0] out_data,
  output logic                         frame_err
);

  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS + 1) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CLASS - 1);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [IDX_W-1:0]               r_idx;
  logic [NUM_CLASS*SCORE_W-1:0]   r_data;
  logic                           r_err;
  logic [SCORE_W-1:0]             w_score;
  logic                           w_in_hs;
  logic                           w_out_hs;
  logic                           w_final;
  logic                           w_early;

  score_round_sat #(
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .acc   (in_data),
    .score (w_score)
  );

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_final  = w_in_hs && (r_idx == c_last_idx);
  assign w_early  = w_in_hs && in_last && (r_idx != c_last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT: if (w_final || w_early) w_next_state = HOLD;
      HOLD:    if (out_ready)          w_next_state = COLLECT;
      default:                         w_next_state = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == COLLECT);
    out_valid = (r_state == HOLD);
  end

  // Slot 0 sits in the top slice; an early in_last pads the untouched tail slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (w_out_hs) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (w_in_hs) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_final) begin
        r_err <= !in_last;
      end else if (w_early) begin
        r_err <= 1'b1;
      end
      for (int s = 0; s < NUM_CLASS; s++) begin
        if (IDX_W'(s) == r_idx) begin
          r_data[SCORE_W*(NUM_CLASS-s)-1 -: SCORE_W] <= w_score;
        end else if (in_last && (IDX_W'(s) > r_idx)) begin
          r_data[SCORE_W*(NUM_CLASS-s)-1 -: SCORE_W] <= SCORE_MIN;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign frame_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fc_score_packer.sv
// ============================================================================
// Module      : tb_fc_score_packer
// Description : Directed self-checking bench for fc_score_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_score_packer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_data;
  logic         frame_err;

  int total;
  int bad;

  fc_score_packer #(
    .NUM_CLASS  (10),
    .ACC_W      (32),
    .FRAC_SHIFT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 160'(in_ready), 160'(1'b1));
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic send_const_frame(input logic [31:0] data);
    for (int k = 0; k < 9; k++) send(data, 1'b0);
    send(data, 1'b1);
  endtask

  logic [31:0]  rnd_in  [5];
  logic [15:0]  rnd_exp [5];

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #10;
    check("rst_in_ready",  160'(in_ready),  160'(1'b1));
    check("rst_out_valid", 160'(out_valid), 160'(1'b0));
    check("rst_out_data",  out_data,        160'h0);
    check("rst_frame_err", 160'(frame_err), 160'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Nominal frame: 0x1280 rounds to 0x13.
    for (int k = 0; k < 9; k++) send(32'h0000_1280, 1'b0);
    check("nom_valid_before_last", 160'(out_valid), 160'(1'b0));
    send(32'h0000_1280, 1'b1);
    check("nom_out_valid", 160'(out_valid), 160'(1'b1));
    check("nom_in_ready",  160'(in_ready),  160'(1'b0));
    check("nom_out_data",  out_data,        {10{16'h0013}});
    check("nom_frame_err", 160'(frame_err), 160'(1'b0));
    take();
    check("nom_after_take_valid", 160'(out_valid), 160'(1'b0));
    check("nom_after_take_ready", 160'(in_ready),  160'(1'b1));

    // Rounding and saturation corners.
    rnd_in[0] = 32'hFFFF_FE80; rnd_exp[0] = 16'hFFFF;
    rnd_in[1] = 32'h7FFF_FFFF; rnd_exp[1] = 16'h7FFF;
    rnd_in[2] = 32'h8000_0000; rnd_exp[2] = 16'h8000;
    rnd_in[3] = 32'h0000_0080; rnd_exp[3] = 16'h0001;
    rnd_in[4] = 32'h0000_007F; rnd_exp[4] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      send_const_frame(rnd_in[i]);
      check($sformatf("round_%0d_data", i), out_data, {10{rnd_exp[i]}});
      check($sformatf("round_%0d_err", i), 160'(frame_err), 160'(1'b0));
      take();
    end

    // Missing in_last on the tenth score, then backpressure in HOLD.
    for (int k = 1; k <= 10; k++) send(32'(k) << 8, 1'b0);
    check("nolast_valid", 160'(out_valid), 160'(1'b1));
    check("nolast_err",   160'(frame_err), 160'(1'b1));
    check("nolast_data",  out_data,
          160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A);
    in_valid = 1'b1;
    in_data  = 32'h0000_7700;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_%0d_in_ready", c),  160'(in_ready),  160'(1'b0));
      check($sformatf("bp_%0d_out_valid", c), 160'(out_valid), 160'(1'b1));
      check($sformatf("bp_%0d_out_data", c),  out_data,
            160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A);
    end
    in_valid = 1'b0;
    take();
    check("nolast_err_cleared", 160'(frame_err), 160'(1'b0));

    // Early in_last on the fourth score pads the tail.
    send(32'h0000_0100, 1'b0);
    send(32'h0000_0200, 1'b0);
    send(32'h0000_0300, 1'b0);
    send(32'h0000_0400, 1'b1);
    check("early_valid", 160'(out_valid), 160'(1'b1));
    check("early_err",   160'(frame_err), 160'(1'b1));
    check("early_data",  out_data,
          {16'h0001, 16'h0002, 16'h0003, 16'h0004, {6{16'h8000}}});
    take();

    // Asynchronous reset between edges after six scores.
    for (int k = 1; k <= 6; k++) send(32'(k + 40) << 8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 160'(out_valid), 160'(1'b0));
    check("arst_out_data",  out_data,        160'h0);
    check("arst_in_ready",  160'(in_ready),  160'(1'b1));
    rst = 1'b0;
    for (int k = 11; k <= 19; k++) send(32'(k) << 8, 1'b0);
    check("arst_not_early", 160'(out_valid), 160'(1'b0));
    send(32'(20) << 8, 1'b1);
    check("arst_frame_valid", 160'(out_valid), 160'(1'b1));
    check("arst_frame_err",   160'(frame_err), 160'(1'b0));
    check("arst_frame_data",  out_data,
          160'h000B_000C_000D_000E_000F_0010_0011_0012_0013_0014);
    take();
    check("final_idle", 160'(out_valid), 160'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
